sm4_tau_pipe: RTL and testbench

//  Multi-lane pipelined SM4 nonlinear/linear transform engine for the round and key-expansion datapaths.
//  Per 32-bit lane, applies the SM4 S-box bytewise (tau), then optionally the round linear transform L
//  or the key-expansion transform L'. Both transforms are selected per beat.
//  Two-stage elastic pipeline with valid/ready on both sides. Full throughput of one beat/cycle.

---
 rtl/sm4_tau_pipe.sv | 135 +++++++++++++
 tb/tb_sm4_tau_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_tau_pipe.sv
// SM4 tau / L / L' transform engine, two-stage elastic pipeline.
// Stage 1 holds S-box outputs, stage 2 holds the linear transform result.
module sm4_tau_pipe #(
    parameter int LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mode,
    input  logic [32*LANES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_mode,
    output logic [32*LANES-1:0]   out_data,
    output logic                  busy
);

    localparam int DW = 32 * LANES;

    // First table byte sits in the top bits so entry b lives at {~b, 3'b0}
    localparam logic [2047:0] SBOX_TBL = {
        128'hd690e9fe_cce13db7_16b614c2_28fb2c05,
        128'h2b679a76_2abe04c3_aa441326_49860699,
        128'h9c4250f4_91ef987a_33540b43_edcfac62,
        128'he4b31ca9_c908e895_80df94fa_758f3fa6,
        128'h4707a7fc_f37317ba_83593c19_e6854fa8,
        128'h686b81b2_7164da8b_f8eb0f4b_70569d35,
        128'h1e240e5e_6358d1a2_25227c3b_01217887,
        128'hd4004657_9fd32752_4c3602e7_a0c4c89e,
        128'heabf8ad2_40c738b5_a3f7f2ce_f96115a1,
        128'he0ae5da4_9b341a55_ad933230_f58cb1e3,
        128'h1df6e22e_8266ca60_c02923ab_0d534e6f,
        128'hd5db3745_defd8e2f_03ff6a72_6d6c5b51,
        128'h8d1baf92_bbddbc7f_11d95c41_1f105ad8,
        128'h0ac13188_a5cd7bbd_2d74d012_b8e5b4b0,
        128'h8969974a_0c96777e_65b9f109_c56ec684,
        128'h18f07dec_3adc4d20_79ee5f3e_d7cb3948
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] w_idx;
        w_idx = {~b, 3'b000};
        return SBOX_TBL[w_idx +: 8];
    endfunction

    function automatic logic [31:0] l_round(input logic [31:0] b);
        return b
             ^ {b[29:0], b[31:30]}
             ^ {b[21:0], b[31:22]}
             ^ {b[13:0], b[31:14]}
             ^ {b[7:0],  b[31:8]};
    endfunction

    function automatic logic [31:0] l_key(input logic [31:0] b);
        return b
             ^ {b[18:0], b[31:19]}
             ^ {b[8:0],  b[31:9]};
    endfunction

    logic          r_s1_valid;
    logic [1:0]    r_s1_mode;
    logic [DW-1:0] r_s1_data;
    logic          r_s2_valid;
    logic [1:0]    r_s2_mode;
    logic [DW-1:0] r_s2_data;

    logic          w_s2_adv;
    logic          w_s1_adv;
    logic          w_push;
    logic [DW-1:0] w_tau;
    logic [DW-1:0] w_lin;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_push   = in_valid && w_s1_adv;

    always_comb begin
        w_tau = '0;
        for (int i = 0; i < 4 * LANES; i++) begin
            if (in_mode == 2'b11) begin
                w_tau[8*i +: 8] = in_data[8*i +: 8];
            end else begin
                w_tau[8*i +: 8] = sbox(in_data[8*i +: 8]);
            end
        end
    end

    always_comb begin
        w_lin = r_s1_data;
        for (int k = 0; k < LANES; k++) begin
            case (r_s1_mode)
                2'b01:   w_lin[32*k +: 32] = l_round(r_s1_data[32*k +: 32]);
                2'b10:   w_lin[32*k +: 32] = l_key(r_s1_data[32*k +: 32]);
                default: w_lin[32*k +: 32] = r_s1_data[32*k +: 32];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 2'b00;
            r_s1_data  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (w_push) begin
                r_s1_mode <= in_mode;
                r_s1_data <= w_tau;
            end
        end
    end

    // Data only moves with a real beat so a stalled or empty output holds its value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_mode  <= 2'b00;
            r_s2_data  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_mode <= r_s1_mode;
                r_s2_data <= w_lin;
            end
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out_mode  = r_s2_mode;
    assign out_data  = r_s2_data;
    assign busy      = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_sm4_tau_pipe.sv
// Bench for sm4_tau_pipe: directed vectors plus a randomized
// valid/ready stream scored against a behavioural SM4 model.
module tb_sm4_tau_pipe;

    localparam int LANES = 4;
    localparam int DW    = 32 * LANES;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_mode = 2'b00;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    out_mode;
    logic [DW-1:0] out_data;
    logic          busy;

    always #5 clk = ~clk;

    sm4_tau_pipe #(.LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mode(out_mode), .out_data(out_data),
        .busy(busy)
    );

    localparam logic [2047:0] SB = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    int n_assert = 0;
    int n_fail   = 0;
    int n_push   = 0;
    int n_pop    = 0;
    logic [DW+1:0] q[$];
    logic          stall_prev = 1'b0;
    logic [DW+1:0] held;

    function automatic logic [7:0] sb(input logic [7:0] b);
        int idx;
        idx = int'(b);
        return SB[2047 - 8*idx -: 8];
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    function automatic logic [DW-1:0] ref_beat(input logic [1:0] m, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        logic [31:0] w, t;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            w = d[32*k +: 32];
            for (int b = 0; b < 4; b++)
                t[8*b +: 8] = (m == 2'd3) ? w[8*b +: 8] : sb(w[8*b +: 8]);
            if (m == 2'd1) t = t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
            if (m == 2'd2) t = t ^ rol(t, 13) ^ rol(t, 23);
            r[32*k +: 32] = t;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW+1:0] obs, input logic [DW+1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scores the handshakes of the coming edge, then advances one clock
    task automatic step();
        logic [DW+1:0] e;
        #1;
        if (stall_prev) begin
            chk("hold_valid", {129'd0, out_valid}, 130'd1);
            chk("hold_data", {out_mode, out_data}, held);
        end
        if (in_valid && in_ready) begin
            q.push_back({in_mode, ref_beat(in_mode, in_data)});
            n_push++;
        end
        if (out_valid && out_ready) begin
            e = (q.size() != 0) ? q.pop_front() : 'x;
            chk("beat", {out_mode, out_data}, e);
            n_pop++;
        end
        stall_prev = out_valid && !out_ready;
        held = {out_mode, out_data};
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int p0, c0, cyc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {129'd0, out_valid}, 130'd0);
        chk("rst_busy", {129'd0, busy}, 130'd0);
        chk("rst_out", {out_mode, out_data}, 130'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {129'd0, in_ready}, 130'd1);

        // Mode 00 known-answer vector
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_mode = 2'b00;
        in_data = {96'd0, 32'h01234567};
        step();
        in_valid = 1'b0;
        chk("kat_lat1", {129'd0, out_valid}, 130'd0);
        step();
        chk("kat_valid", {129'd0, out_valid}, 130'd1);
        chk("kat_tau", {out_mode, out_data},
            {2'b00, 128'hd6d6d6d6_d6d6d6d6_d6d6d6d6_90f473a2});
        step();

        // Zero vector through L, L' and bypass
        for (int m = 1; m < 4; m++) begin
            in_valid = 1'b1;
            in_mode = 2'(m);
            in_data = '0;
            step();
            in_valid = 1'b0;
            step();
            chk("zero_valid", {129'd0, out_valid}, 130'd1);
            case (m)
                1: chk("zero_L", {out_mode, out_data}, {2'b01, {4{32'h5b5b5b5b}}});
                2: chk("zero_Lp", {out_mode, out_data}, {2'b10, {4{32'h67676767}}});
                default: chk("zero_byp", {out_mode, out_data}, 130'h3_0000_0000_0000_0000_0000_0000_0000_0000);
            endcase
            step();
        end

        // Back-to-back stream of 16 beats
        p0 = n_pop;
        for (int i = 0; i < 18; i++) begin
            in_valid = (i < 16);
            in_mode = 2'($urandom);
            in_data = rnd_data();
            step();
            chk("strm_in_ready", {129'd0, in_ready}, 130'd1);
            chk("strm_out_valid", {129'd0, out_valid}, {129'd0, (i >= 1 && i <= 16)});
            chk("strm_busy", {129'd0, busy}, {129'd0, (i <= 16)});
        end
        chk("strm_count", 130'(n_pop - p0), 130'd16);

        // Downstream stall while the source keeps offering beats
        p0 = n_push;
        c0 = n_pop;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_mode = 2'($urandom);
            in_data = rnd_data();
            step();
        end
        chk("stall_pushed", 130'(n_push - p0), 130'd2);
        chk("stall_in_ready", {129'd0, in_ready}, 130'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while ((q.size() != 0 || busy) && cyc < 50) begin
            step();
            cyc++;
        end
        chk("stall_drained", 130'(n_pop - c0), 130'd2);
        chk("stall_q_empty", 130'(q.size()), 130'd0);

        // Random valid/ready with random modes
        p0 = n_push;
        cyc = 0;
        while (n_push - p0 < 1000 && cyc < 20000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_mode = 2'($urandom);
            in_data = rnd_data();
            step();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while ((q.size() != 0 || busy) && cyc < 50) begin
            step();
            cyc++;
        end
        chk("rnd_pushed", 130'(n_push - p0), 130'd1000);
        chk("rnd_q_empty", 130'(q.size()), 130'd0);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_mode = 2'($urandom);
            in_data = rnd_data();
            step();
        end
        chk("full_busy", {129'd0, busy}, 130'd1);
        chk("full_in_ready", {129'd0, in_ready}, 130'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {129'd0, out_valid}, 130'd0);
        chk("arst_busy", {129'd0, busy}, 130'd0);
        q.delete();
        stall_prev = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", {129'd0, in_ready}, 130'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_no_stale", {129'd0, out_valid}, 130'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
